// File: rtl/seq_divider_32bit.sv
// -----------------------------------------------------------------------------
// seq_divider_32bit
//   Iterative unsigned divider using the radix-2 restoring algorithm. It
//   produces one quotient bit per clock behind a start/done handshake.
//
//   Ports
//     clock        in   rising-edge clock
//     reset_n      in   asynchronous, active-low reset
//     start        in   request a division; sampled only while not busy
//     dividend     in   numerator, captured on the accepting edge
//     divisor      in   denominator, captured on the accepting edge
//     busy         out  high from the accepting edge until the end of FIN
//     done         out  one-cycle pulse while the results are presented
//     quotient     out  dividend / divisor (all ones on divide by zero)
//     remainder    out  dividend % divisor (dividend on divide by zero)
//     div_by_zero  out  high with done when the captured divisor was zero
//
//   Timing (accepting edge = cycle 0)
//     non-zero divisor : done in cycle WIDTH+1
//     zero divisor     : done in cycle 1
//   Results hold between operations and change only on entry to FIN.
// -----------------------------------------------------------------------------
module seq_divider_32bit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem_r;   // partial remainder, always < divisor between steps
  logic [WIDTH-1:0] quo_r;   // shifts dividend out the top, quotient in the bottom
  logic [WIDTH-1:0] div_r;   // captured divisor

  // One restoring step. The shifted remainder carries an extra top bit, so the
  // compare and subtract are done WIDTH+1 wide and cannot overflow.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   div_ext;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // here by a default at the top, so no latch is inferred.
  always_comb begin
    shifted  = {rem_r, quo_r[WIDTH-1]};
    div_ext  = {1'b0, div_r};
    fits     = (shifted >= div_ext);
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo_r[WIDTH-2:0], fits};
    if (fits) begin
      rem_next = WIDTH'(shifted - div_ext);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      div_r       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            count <= '0;
            rem_r <= '0;
            quo_r <= dividend;
            div_r <= divisor;
            if (divisor == '0) begin
              // Skip the iterations; the result is defined directly.
              state       <= FIN;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          rem_r <= rem_next;
          quo_r <= quo_next;
          count <= count + 1'b1;
          if (count == LAST_ITER) begin
            // The final step's result goes straight to the outputs so they
            // are valid for the whole FIN cycle.
            state       <= FIN;
            done        <= 1'b1;
            quotient    <= quo_next;
            remainder   <= rem_next;
            div_by_zero <= 1'b0;
          end
        end

        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_32bit.sv
// -----------------------------------------------------------------------------
// tb_seq_divider_32bit
//   Self-checking bench for seq_divider_32bit (WIDTH = 32). Expected results
//   come from plain '/' and '%' arithmetic, with the divide-by-zero rule
//   applied on top.
// -----------------------------------------------------------------------------
module tb_seq_divider_32bit;

  localparam int W = 32;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider_32bit #(.WIDTH(W), .CNT_W(6)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } result_t;

  function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    result_t res;
    if (b == 0) begin
      res.q  = '1;
      res.r  = a;
      res.dz = 1'b1;
    end else begin
      res.q  = a / b;
      res.r  = a % b;
      res.dz = 1'b0;
    end
    return res;
  endfunction

  // Issues one operation and waits for its done pulse. lat is the cycle in
  // which done was seen (accepting edge = cycle 0), or -1 on timeout.
  // busy_low_cycles counts cycles before done in which busy was low.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output result_t got, output int lat, output int busy_low_cycles);
    got = '0;
    lat = -1;
    busy_low_cycles = 0;
    @(negedge clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      if (!busy) busy_low_cycles++;
      if (done) begin
        lat    = c;
        got.q  = quotient;
        got.r  = remainder;
        got.dz = div_by_zero;
        break;
      end
    end
  endtask

  task automatic check_result(input string name, input result_t got, input result_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b",
               name, got.q, got.r, got.dz, exp.q, exp.r, exp.dz);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b, expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_basic();
    result_t got;
    int lat, bl;
    run_op(32'd100, 32'd7, got, lat, bl);
    check_int("basic_latency", lat, W + 1);
    check_int("basic_busy_low_before_done", bl, 0);
    check_result("basic_100_div_7", got, model(32'd100, 32'd7));
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_after_fin: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_full_scale();
    result_t got;
    int lat, bl;
    run_op(32'hFFFF_FFFF, 32'd1, got, lat, bl);
    check_result("full_scale_div_1", got, model(32'hFFFF_FFFF, 32'd1));
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, got, lat, bl);
    check_result("full_scale_div_self", got, model(32'hFFFF_FFFF, 32'hFFFF_FFFF));
    run_op(32'hFFFF_FFFE, 32'h8000_0001, got, lat, bl);
    check_result("full_scale_large_divisor", got, model(32'hFFFF_FFFE, 32'h8000_0001));
  endtask

  task automatic test_div_by_zero();
    result_t got;
    result_t held;
    int lat, bl;
    run_op(32'd5, 32'd0, got, lat, bl);
    check_int("dbz_latency", lat, 1);
    check_result("dbz_5_div_0", got, model(32'd5, 32'd0));
    repeat (4) @(negedge clock);
    held = '{q: quotient, r: remainder, dz: div_by_zero};
    check_result("dbz_outputs_hold", held, model(32'd5, 32'd0));
    run_op(32'd9, 32'd3, got, lat, bl);
    check_result("dbz_then_9_div_3", got, model(32'd9, 32'd3));
  endtask

  task automatic test_ignore_busy_start();
    result_t exp;
    result_t got;
    int dones;
    bit seen;
    exp   = model(32'd3, 32'd10);
    got   = '0;
    dones = 0;
    seen  = 0;
    @(negedge clock);
    dividend = 32'd3;
    divisor  = 32'd10;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      if (c == 10) begin
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        if (!seen) got = '{q: quotient, r: remainder, dz: div_by_zero};
        seen = 1;
      end
    end
    check_result("busy_start_ignored_result", got, exp);
    check_int("busy_start_single_done", dones, 1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_idle_after: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_reset_abort();
    result_t got;
    int lat, bl, dones;
    dones = 0;
    @(negedge clock);
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (12) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_abort_outputs: got busy=%b done=%b q=%h r=%h dz=%b, expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (done) dones++;
    end
    check_int("reset_abort_no_done", dones, 0);
    run_op(32'd1000, 32'd3, got, lat, bl);
    check_result("reset_abort_then_1000_div_3", got, model(32'd1000, 32'd3));
  endtask

  task automatic test_back_to_back();
    localparam int N = 300;
    result_t exp_q[$];
    result_t exp;
    result_t got;
    int issued, seen, bad, done_gap_bad;
    logic [W-1:0] b;
    logic prev_done;
    issued = 0;
    seen = 0;
    bad = 0;
    done_gap_bad = 0;
    prev_done = 1'b0;
    @(negedge clock);
    for (int cyc = 0; cyc < 30000 && seen < N; cyc++) begin
      if (cyc != 0) @(negedge clock);
      // the cycle after a done pulse must be IDLE before the next accept
      if (prev_done && busy) done_gap_bad++;
      prev_done = done;
      if (done) begin
        got = '{q: quotient, r: remainder, dz: div_by_zero};
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL b2b_unexpected_done: got done=1, expected no done");
        end else begin
          exp = exp_q.pop_front();
          checks++;
          if (got !== exp) begin
            errors++;
            $display("FAIL b2b_result_%0d: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b",
                     seen, got.q, got.r, got.dz, exp.q, exp.r, exp.dz);
          end
        end
        seen++;
      end
      if (!busy && issued < N) begin
        case ($urandom_range(7, 0))
          0:       b = '0;
          1:       b = 32'd1;
          2, 3:    b = $urandom_range(255, 2);
          default: b = $urandom;
        endcase
        divisor  = b;
        dividend = ($urandom_range(3, 0) == 0) ? W'($urandom_range(1000, 0)) : W'($urandom);
        start    = 1'b1;
        exp_q.push_back(model(dividend, divisor));
        issued++;
        @(posedge clock);
        #1;
        // scramble the operand pins; only captured values may matter
        dividend = $urandom;
        divisor  = $urandom;
        if (issued == N) start = 1'b0;
      end
    end
    start = 1'b0;
    check_int("b2b_done_count", seen, N);
    check_int("b2b_unexpected_dones", bad, 0);
    check_int("b2b_idle_gap_violations", done_gap_bad, 0);
    check_int("b2b_queue_left", exp_q.size(), 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_scale();
    test_div_by_zero();
    test_ignore_busy_start();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
